seq_window_detector: RTL and testbench

SEQ_WINDOW_DETECTOR -- requirements
Module: seq_window_detector

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_pattern_match.sv | 15 +
 rtl/seq_window_detector.sv | 136 +++++++++++++
 tb/tb_seq_window_detector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sliding-window serial pattern detector.
// Holds the FSM encoding, the mode constants and the index-width helper.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_e;

    localparam logic MODE_OVL  = 1'b0;
    localparam logic MODE_NOVL = 1'b1;

    // Width of a slot index; a single-slot table still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_det_pattern_match.sv
// One masked comparator: hit when enabled and every compared bit of the
// window equals the programmed pattern bit.
module seq_det_pattern_match #(
    parameter int WIN = 3
) (
    input  logic [WIN-1:0] win_i,
    input  logic [WIN-1:0] val_i,
    input  logic [WIN-1:0] mask_i,
    input  logic           en_i,
    output logic           hit_o
);

    assign hit_o = en_i && (((win_i ^ val_i) & mask_i) == '0);

endmodule

// File: rtl/seq_window_detector.sv
// Serial bit-stream detector: a WIN-bit sliding window compared against NPAT
// programmable masked patterns, with overlap / non-overlap modes and a match counter.
module seq_window_detector
    import seq_det_pkg::*;
#(
    parameter  int WIN   = 3,
    parameter  int NPAT  = 2,
    parameter  int CNT_W = 8,
    localparam int IDX_W = idx_width(NPAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             pat_wr,
    input  logic [IDX_W-1:0] pat_idx,
    input  logic [WIN-1:0]   pat_val,
    input  logic [WIN-1:0]   pat_mask,
    input  logic             pat_en,
    input  logic             cnt_clr,
    output logic             out,
    output logic [NPAT-1:0]  match_vec,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                FILL_W    = $clog2(WIN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Only the WIN-1 newest bits need storing: the oldest bit of the current
    // window is always shifted out before the next comparison.
    logic [WIN-2:0]   hist_q;
    logic [FILL_W-1:0] fill_q;
    det_state_e        state_q;
    logic              armed_q;
    logic              out_q;
    logic [NPAT-1:0]   match_vec_q;
    logic [CNT_W-1:0]  match_cnt_q;

    logic [WIN-1:0]    pat_val_q  [NPAT];
    logic [WIN-1:0]    pat_mask_q [NPAT];
    logic [NPAT-1:0]   pat_en_q;

    logic [WIN-1:0]    win_d;
    logic [FILL_W-1:0] fill_d;
    logic              full_d;
    logic              cmp_en;
    logic [NPAT-1:0]   hit;
    logic              any_hit;
    logic              novl_clear;

    always_comb begin
        win_d      = {hist_q, in};
        fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        full_d     = (fill_d == FILL_FULL);
        cmp_en     = in_valid && full_d;
        any_hit    = |hit;
        novl_clear = any_hit && (mode == MODE_NOVL);
    end

    // Comparators see the post-shift window and the table as it stood before this edge.
    for (genvar g = 0; g < NPAT; g++) begin : g_match
        seq_det_pattern_match #(
            .WIN(WIN)
        ) u_match (
            .win_i (win_d),
            .val_i (pat_val_q[g]),
            .mask_i(pat_mask_q[g]),
            .en_i  (pat_en_q[g] & cmp_en),
            .hit_o (hit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q      <= '0;
            fill_q      <= '0;
            state_q     <= FILL;
            armed_q     <= 1'b0;
            out_q       <= 1'b0;
            match_vec_q <= '0;
            match_cnt_q <= '0;
            pat_en_q    <= '0;
            for (int k = 0; k < NPAT; k++) begin
                pat_val_q[k]  <= '0;
                pat_mask_q[k] <= '0;
            end
        end else begin
            out_q       <= any_hit;
            match_vec_q <= hit;

            if (in_valid) begin
                hist_q <= win_d[WIN-2:0];
                fill_q <= novl_clear ? '0 : fill_d;
            end

            case (state_q)
                FILL: begin
                    if (in_valid && full_d && !novl_clear) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (novl_clear) begin
                        state_q <= FILL;
                        armed_q <= 1'b0;
                    end
                end
            endcase

            // Clear wins over a same-edge increment.
            if (cnt_clr) begin
                match_cnt_q <= '0;
            end else if (any_hit && (match_cnt_q != CNT_MAX)) begin
                match_cnt_q <= match_cnt_q + CNT_W'(1);
            end

            for (int k = 0; k < NPAT; k++) begin
                if (pat_wr && (pat_idx == IDX_W'(k))) begin
                    pat_val_q[k]  <= pat_val;
                    pat_mask_q[k] <= pat_mask;
                    pat_en_q[k]   <= pat_en;
                end
            end
        end
    end

    assign out       = out_q;
    assign match_vec = match_vec_q;
    assign match_cnt = match_cnt_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_seq_window_detector.sv
// Bench for seq_window_detector (WIN=3, NPAT=2): directed vector table,
// hand-written corner sequences, then random traffic against a queue-based model.
module tb_seq_window_detector;

    logic       clk = 1'b0;
    logic       reset, d_in, in_valid, mode, pat_wr, pat_en, cnt_clr;
    logic [0:0] pat_idx;
    logic [2:0] pat_val, pat_mask;
    logic       out_w, out_s;
    logic [1:0] vec_w, vec_s;
    logic [7:0] cnt_w;
    logic [1:0] cnt_s;
    logic       armed_w, armed_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_window_detector #(.WIN(3), .NPAT(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in(d_in), .in_valid(in_valid), .mode(mode),
        .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_val(pat_val), .pat_mask(pat_mask),
        .pat_en(pat_en), .cnt_clr(cnt_clr), .out(out_w), .match_vec(vec_w),
        .match_cnt(cnt_w), .armed(armed_w)
    );

    seq_window_detector #(.WIN(3), .NPAT(2), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in(d_in), .in_valid(in_valid), .mode(mode),
        .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_val(pat_val), .pat_mask(pat_mask),
        .pat_en(pat_en), .cnt_clr(cnt_clr), .out(out_s), .match_vec(vec_s),
        .match_cnt(cnt_s), .armed(armed_s)
    );

    typedef struct {
        logic       rst, vld, din, md, wr;
        logic [0:0] idx;
        logic [2:0] val, mask;
        logic       en, clr;
        logic       e_out;
        logic [1:0] e_vec;
        logic       e_armed;
        logic [7:0] e_cnt;
        logic [1:0] e_cnt_s;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, vld, din, md, wr, input logic [0:0] idx,
                         input logic [2:0] val, mask, input logic en, clr);
        reset = rst; in_valid = vld; d_in = din; mode = md; pat_wr = wr;
        pat_idx = idx; pat_val = val; pat_mask = mask; pat_en = en; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // ---- table builders ----
    task automatic t_rst();
        tbl.push_back('{1, 0, 0, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0, 0, 2'b0, 0, 8'd0, 2'd0});
    endtask

    task automatic t_wr(input logic [0:0] idx, input logic [2:0] val, mask, input logic en,
                        input logic ea, input logic [7:0] ec, input logic [1:0] ecs);
        tbl.push_back('{0, 0, 0, 0, 1, idx, val, mask, en, 0, 0, 2'b0, ea, ec, ecs});
    endtask

    task automatic t_bit(input logic md, din, clr, eo, input logic [1:0] ev, input logic ea,
                         input logic [7:0] ec, input logic [1:0] ecs);
        tbl.push_back('{0, 1, din, md, 0, 1'b0, 3'b0, 3'b0, 0, clr, eo, ev, ea, ec, ecs});
    endtask

    task automatic t_idle(input logic md, ea, input logic [7:0] ec, input logic [1:0] ecs);
        tbl.push_back('{0, 0, 1, md, 0, 1'b0, 3'b0, 3'b0, 0, 0, 0, 2'b0, ea, ec, ecs});
    endtask

    task automatic t_tbl_a(); // slots 0=011, 1=110, full masks
        t_wr(1'b0, 3'b011, 3'b111, 1, 0, 0, 0);
        t_wr(1'b1, 3'b110, 3'b111, 1, 0, 0, 0);
    endtask

    // ---- behavioural model: the valid bits seen since the window last restarted ----
    int         m_hist[$];
    logic [2:0] m_val [2];
    logic [2:0] m_mask[2];
    logic       m_en  [2];
    int         m_cnt, m_cnt_s, e_out, e_vec, e_armed;

    task automatic m_step(input logic rst, vld, din, md, wr, input logic [0:0] idx,
                          input logic [2:0] val, mask, input logic en, clr);
        int w;
        if (rst) begin
            m_hist.delete();
            for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_mask[k] = 0; m_en[k] = 0; end
            m_cnt = 0; m_cnt_s = 0; e_out = 0; e_vec = 0;
        end else begin
            e_vec = 0;
            if (vld) begin
                m_hist.push_back(int'(din));
                if (m_hist.size() > 3) m_hist.delete(0);
                if (m_hist.size() == 3) begin
                    w = m_hist[0] * 4 + m_hist[1] * 2 + m_hist[2];
                    for (int k = 0; k < 2; k++)
                        if (m_en[k] && (((w ^ int'(m_val[k])) & int'(m_mask[k])) == 0))
                            e_vec |= (1 << k);
                    if (e_vec != 0 && md) m_hist.delete();
                end
            end
            e_out = (e_vec != 0);
            if (clr) begin
                m_cnt = 0; m_cnt_s = 0;
            end else if (e_out != 0) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            if (wr) begin m_val[idx] = val; m_mask[idx] = mask; m_en[idx] = en; end
        end
        e_armed = (m_hist.size() == 3);
    endtask

    initial begin
        logic rr, vv, dd, md, ww, ee, cc;
        logic [0:0] ii;
        logic [2:0] pv, pm;

        reset = 1; in_valid = 0; d_in = 0; mode = 0; pat_wr = 0;
        pat_idx = 0; pat_val = 0; pat_mask = 0; pat_en = 0; cnt_clr = 0;
        repeat (2) @(posedge clk);
        #1;

        // Overlapping detection of 011 / 110
        t_rst(); t_tbl_a();
        t_bit(0, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 0, 0, 0, 2'b00, 1, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 1, 0, 0);
        t_bit(0, 1, 0, 1, 2'b01, 1, 1, 1);
        t_bit(0, 0, 0, 1, 2'b10, 1, 2, 2);
        t_bit(0, 0, 0, 0, 2'b00, 1, 2, 2);
        t_bit(0, 1, 0, 0, 2'b00, 1, 2, 2);
        t_bit(0, 1, 0, 1, 2'b01, 1, 3, 3);
        // Non-overlapping: match restarts the window
        t_rst(); t_tbl_a();
        t_bit(1, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(1, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(1, 1, 0, 1, 2'b01, 0, 1, 1);
        t_bit(1, 0, 0, 0, 2'b00, 0, 1, 1);
        t_bit(1, 1, 0, 0, 2'b00, 0, 1, 1);
        t_bit(1, 1, 0, 1, 2'b01, 0, 2, 2);
        // Don't-care middle bit, slot 1 disabled
        t_rst(); t_wr(1'b0, 3'b101, 3'b101, 1, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 1, 2'b01, 1, 1, 1);
        t_bit(0, 0, 0, 0, 2'b00, 1, 1, 1);
        t_bit(0, 1, 0, 1, 2'b01, 1, 2, 2);
        // Idle gap between bits
        t_rst(); t_tbl_a();
        t_bit(0, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_idle(0, 0, 0, 0); t_idle(0, 0, 0, 0); t_idle(0, 0, 0, 0);
        t_bit(0, 1, 0, 1, 2'b01, 1, 1, 1);
        t_idle(0, 1, 1, 1);
        // Reset mid-stream discards partial window
        t_rst(); t_tbl_a();
        t_bit(0, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_rst(); t_tbl_a();
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 0, 0, 1, 2'b10, 1, 1, 1);
        // All-don't-care slot, counter saturation and clear
        t_rst(); t_wr(1'b0, 3'b000, 3'b000, 1, 0, 0, 0);
        t_bit(0, 1, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 0, 0, 0, 2'b00, 0, 0, 0);
        t_bit(0, 1, 0, 1, 2'b01, 1, 1, 1);
        t_bit(0, 0, 0, 1, 2'b01, 1, 2, 2);
        t_bit(0, 1, 0, 1, 2'b01, 1, 3, 3);
        t_bit(0, 1, 0, 1, 2'b01, 1, 4, 3);
        t_bit(0, 0, 1, 1, 2'b01, 1, 0, 0);
        t_bit(0, 1, 0, 1, 2'b01, 1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].md, tbl[i].wr, tbl[i].idx,
                  tbl[i].val, tbl[i].mask, tbl[i].en, tbl[i].clr);
            check($sformatf("tbl[%0d].out", i), 32'(out_w), 32'(tbl[i].e_out));
            check($sformatf("tbl[%0d].vec", i), 32'(vec_w), 32'(tbl[i].e_vec));
            check($sformatf("tbl[%0d].armed", i), 32'(armed_w), 32'(tbl[i].e_armed));
            check($sformatf("tbl[%0d].cnt", i), 32'(cnt_w), 32'(tbl[i].e_cnt));
            check($sformatf("tbl[%0d].cnt_s", i), 32'(cnt_s), 32'(tbl[i].e_cnt_s));
        end

        // Table write on the same edge as a completing bit uses the old contents
        drive(1, 0, 0, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        drive(0, 0, 0, 0, 1, 1'b0, 3'b111, 3'b111, 1, 0);
        drive(0, 1, 1, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        drive(0, 1, 1, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        drive(0, 1, 1, 0, 1, 1'b0, 3'b111, 3'b111, 0, 0);
        check("wr_same_edge.out", 32'(out_w), 32'd1);
        check("wr_same_edge.vec", 32'(vec_w), 32'd1);
        drive(0, 1, 1, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("wr_after.out", 32'(out_w), 32'd0);
        check("wr_after.armed", 32'(armed_w), 32'd1);

        // Mode change keeps the window; non-overlap then needs 3 fresh bits
        drive(1, 0, 0, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        drive(0, 0, 0, 0, 1, 1'b0, 3'b111, 3'b111, 1, 0);
        repeat (3) drive(0, 1, 1, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("mode_ovl.out", 32'(out_w), 32'd1);
        drive(0, 1, 1, 1, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("mode_sw.out", 32'(out_w), 32'd1);
        check("mode_sw.armed", 32'(armed_w), 32'd0);
        drive(0, 1, 1, 1, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        drive(0, 1, 1, 1, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("mode_novl_gap.out", 32'(out_w), 32'd0);
        drive(0, 1, 1, 1, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("mode_novl_3rd.out", 32'(out_w), 32'd1);
        check("mode_novl_3rd.cnt", 32'(cnt_w), 32'd3);

        // Reset overrides valid, write and clear on the same edge
        drive(1, 1, 1, 0, 1, 1'b0, 3'b111, 3'b111, 1, 1);
        check("rst_ovr.armed", 32'(armed_w), 32'd0);
        check("rst_ovr.cnt", 32'(cnt_w), 32'd0);
        repeat (3) drive(0, 1, 1, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        check("rst_ovr_nowr.out", 32'(out_w), 32'd0);
        check("rst_ovr_nowr.armed", 32'(armed_w), 32'd1);

        // Random traffic against the model
        drive(1, 0, 0, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        m_step(1, 0, 0, 0, 0, 1'b0, 3'b0, 3'b0, 0, 0);
        md = 0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            vv = ($urandom_range(0, 9) < 7);
            dd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) md = ~md;
            ww = ($urandom_range(0, 19) == 0);
            ii = 1'($urandom_range(0, 1));
            pv = 3'($urandom_range(0, 7));
            pm = 3'($urandom_range(0, 7));
            ee = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 39) == 0);
            m_step(rr, vv, dd, md, ww, ii, pv, pm, ee, cc);
            drive(rr, vv, dd, md, ww, ii, pv, pm, ee, cc);
            check($sformatf("rnd[%0d].out", i), 32'(out_w), 32'(e_out));
            check($sformatf("rnd[%0d].vec", i), 32'(vec_w), 32'(e_vec));
            check($sformatf("rnd[%0d].armed", i), 32'(armed_w), 32'(e_armed));
            check($sformatf("rnd[%0d].cnt", i), 32'(cnt_w), 32'(m_cnt));
            check($sformatf("rnd[%0d].cnt_s", i), 32'(cnt_s), 32'(m_cnt_s));
            check($sformatf("rnd[%0d].out_s", i), 32'(out_s), 32'(e_out));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
